// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 raster timing constants and the range decode helper
package vga_timing_pkg;
  localparam int CNT_W    = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  function automatic logic in_range(input int unsigned cnt, input int unsigned lo, input int unsigned hi);
    return cnt >= lo && cnt < hi;
  endfunction
endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: system-clock divider producing the step strobe and the registered pixel tick
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  assign step = en && div == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (en) div <= step ? '0 : div + 1'b1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator; optional pre_* lookahead outputs under VGA_PREFETCH_EN
module vga_timing_gen #(
  parameter int CNT_W    = vga_timing_pkg::CNT_W,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int PREFETCH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_PREFETCH_EN
  ,
  output logic             pre_de,
  output logic [CNT_W-1:0] pre_x,
  output logic [CNT_W-1:0] pre_y
`endif
);
  import vga_timing_pkg::*;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(HT - 1);
  localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(VT - 1);
  logic step, h_wrap, v_wrap;
  logic [CNT_W-1:0] h_nx, v_nx;
  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .step(step),
    .tick(pix_tick)
  );
  always_comb begin
    h_wrap = {1'b0, h_cnt} == H_LAST;
    v_wrap = {1'b0, v_cnt} == V_LAST;
    h_nx   = h_wrap ? '0 : h_cnt + 1'b1;
    v_nx   = !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 1'b1;
  end
  // status is decoded from the next counter values so it lands together with them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt       <= CNT_W'(HT - 1);
      v_cnt       <= CNT_W'(VT - 1);
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (step) begin
      h_cnt       <= h_nx;
      v_cnt       <= v_nx;
      hs          <= in_range(32'(h_nx), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      vs          <= in_range(32'(v_nx), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      de          <= in_range(32'(h_nx), 0, H_ACTIVE) && in_range(32'(v_nx), 0, V_ACTIVE);
      line_start  <= h_nx == '0;
      frame_start <= h_nx == '0 && v_nx == '0;
    end
`ifdef VGA_PREFETCH_EN
  logic [CNT_W:0] ph;
  logic ph_wrap;
  logic [CNT_W-1:0] px_nx, py_nx;
  always_comb begin
    ph      = {1'b0, h_nx} + (CNT_W+1)'(PREFETCH);
    ph_wrap = ph >= (CNT_W+1)'(HT);
    px_nx   = CNT_W'(ph_wrap ? ph - (CNT_W+1)'(HT) : ph);
    py_nx   = !ph_wrap ? v_nx : ({1'b0, v_nx} == V_LAST) ? '0 : v_nx + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_x  <= CNT_W'(PREFETCH - 1);
      pre_y  <= '0;
      pre_de <= 1'b1;
    end else if (step) begin
      pre_x  <= px_nx;
      pre_y  <= py_nx;
      pre_de <= in_range(32'(px_nx), 0, H_ACTIVE) && in_range(32'(py_nx), 0, V_ACTIVE);
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table-driven bench for the default 640x480 build and a tiny HS_POL/VS_POL=1 build
module tb_vga_timing_gen;
  typedef struct {
    int h, v;
    bit hs, vs, de, ls, fs;
    int px, py;
    bit pd;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, en = 1'b1, rst_s = 1'b0, en_s = 1'b1;
  logic d_tick_o, d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_h, d_v;
  logic s_tick_o, s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0] s_h, s_v;
`ifdef VGA_PREFETCH_EN
  logic d_pd, s_pd;
  logic [9:0] d_px, d_py;
  logic [3:0] s_px, s_py;
`endif
  int n_cmp = 0, n_bad = 0;
  int n_ticks, hs_low, per_bad, s_clk, s_tick_bad;

  always #5 clk = ~clk;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst), .en(en), .pix_tick(d_tick_o), .h_cnt(d_h), .v_cnt(d_v),
    .hs(d_hs), .vs(d_vs), .de(d_de), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_PREFETCH_EN
    , .pre_de(d_pd), .pre_x(d_px), .pre_y(d_py)
`endif
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PREFETCH(2)
  ) u_s (
    .clk(clk), .rst(rst_s), .en(en_s), .pix_tick(s_tick_o), .h_cnt(s_h), .v_cnt(s_v),
    .hs(s_hs), .vs(s_vs), .de(s_de), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_PREFETCH_EN
    , .pre_de(s_pd), .pre_x(s_px), .pre_y(s_py)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic d_chk(input vec_t r, input string t);
    chk({t, "_h"}, int'(d_h), r.h);
    chk({t, "_v"}, int'(d_v), r.v);
    chk({t, "_hs"}, int'(d_hs), int'(r.hs));
    chk({t, "_vs"}, int'(d_vs), int'(r.vs));
    chk({t, "_de"}, int'(d_de), int'(r.de));
    chk({t, "_ls"}, int'(d_ls), int'(r.ls));
    chk({t, "_fs"}, int'(d_fs), int'(r.fs));
`ifdef VGA_PREFETCH_EN
    chk({t, "_px"}, int'(d_px), r.px);
    chk({t, "_py"}, int'(d_py), r.py);
    chk({t, "_pd"}, int'(d_pd), int'(r.pd));
`endif
  endtask

  task automatic s_chk(input vec_t r, input string t);
    chk({t, "_h"}, int'(s_h), r.h);
    chk({t, "_v"}, int'(s_v), r.v);
    chk({t, "_hs"}, int'(s_hs), int'(r.hs));
    chk({t, "_vs"}, int'(s_vs), int'(r.vs));
    chk({t, "_de"}, int'(s_de), int'(r.de));
    chk({t, "_ls"}, int'(s_ls), int'(r.ls));
    chk({t, "_fs"}, int'(s_fs), int'(r.fs));
  endtask

  task automatic d_step(output int clks);
    clks = 0;
    do begin
      @(posedge clk); #1;
      clks++;
    end while (!d_tick_o && clks < 100);
    if (!d_tick_o) chk("tick_timeout", 0, 1);
    n_ticks++;
    if (!d_hs) hs_low++;
  endtask

  task automatic d_goto(input int h);
    int c, g;
    g = 0;
    while (int'(d_h) != h && g < 900) begin
      d_step(c);
      if (c != 4) per_bad++;
      g++;
    end
    if (int'(d_h) != h) chk("goto_h", int'(d_h), h);
  endtask

  task automatic s_goto(input int h, input int v);
    int g;
    g = 0;
    while ((int'(s_h) != h || int'(s_v) != v) && g < 400) begin
      @(posedge clk); #1;
      s_clk++;
      if (!s_tick_o) s_tick_bad++;
      g++;
    end
    if (int'(s_h) != h || int'(s_v) != v) chk("s_goto", int'(s_h) * 100 + int'(s_v), h * 100 + v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t dv[12], sv[18], rst_d, rst_sm;
    int c, hold_bad;
    dv = '{
      '{0,   0, 1, 1, 1, 1, 1, 2,   0, 1},
      '{637, 0, 1, 1, 1, 0, 0, 639, 0, 1},
      '{638, 0, 1, 1, 1, 0, 0, 640, 0, 0},
      '{639, 0, 1, 1, 1, 0, 0, 641, 0, 0},
      '{640, 0, 1, 1, 0, 0, 0, 642, 0, 0},
      '{655, 0, 1, 1, 0, 0, 0, 657, 0, 0},
      '{656, 0, 0, 1, 0, 0, 0, 658, 0, 0},
      '{751, 0, 0, 1, 0, 0, 0, 753, 0, 0},
      '{752, 0, 1, 1, 0, 0, 0, 754, 0, 0},
      '{797, 0, 1, 1, 0, 0, 0, 799, 0, 0},
      '{798, 0, 1, 1, 0, 0, 0, 0,   1, 1},
      '{799, 0, 1, 1, 0, 0, 0, 1,   1, 1}
    };
    sv = '{
      '{0,  0, 0, 0, 1, 1, 1, 0, 0, 0},
      '{7,  0, 0, 0, 1, 0, 0, 0, 0, 0},
      '{8,  0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{9,  0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{10, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{12, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{13, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{15, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0,  1, 0, 0, 1, 1, 0, 0, 0, 0},
      '{7,  5, 0, 0, 1, 0, 0, 0, 0, 0},
      '{0,  6, 0, 0, 0, 1, 0, 0, 0, 0},
      '{15, 6, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0,  7, 0, 1, 0, 1, 0, 0, 0, 0},
      '{11, 8, 1, 1, 0, 0, 0, 0, 0, 0},
      '{15, 8, 0, 1, 0, 0, 0, 0, 0, 0},
      '{0,  9, 0, 0, 0, 1, 0, 0, 0, 0},
      '{15, 9, 0, 0, 0, 0, 0, 0, 0, 0},
      '{0,  0, 0, 0, 1, 1, 1, 0, 0, 0}
    };
    rst_d  = '{799, 520, 1, 1, 0, 0, 0, 1, 0, 1};
    rst_sm = '{15, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    rst_s = 1'b1;
    per_bad = 0;
    s_clk = 0;
    s_tick_bad = 0;
    // reset state and first pixel
    repeat (3) @(posedge clk);
    #1;
    d_chk(rst_d, "rst");
    chk("rst_tick", int'(d_tick_o), 0);
    @(negedge clk) rst = 1'b0;
    d_step(c);
    chk("first_tick_clks", c, 4);
    d_chk(dv[0], "first");
    n_ticks = 0;
    hs_low = 0;
    // line 0 walked through the table
    for (int i = 0; i < 12; i++) begin
      d_goto(dv[i].h);
      d_chk(dv[i], $sformatf("d%0d", i));
    end
    d_step(c);
    chk("line1_h", int'(d_h), 0);
    chk("line1_v", int'(d_v), 1);
    chk("line1_ls", int'(d_ls), 1);
    chk("line1_fs", int'(d_fs), 0);
    chk("line_ticks", n_ticks, 800);
    chk("hs_low_ticks", hs_low, 96);
    // en low for 37 clocks at h=100
    d_goto(100);
    @(negedge clk) en = 1'b0;
    hold_bad = 0;
    repeat (37) begin
      @(posedge clk); #1;
      if (d_tick_o || d_h != 10'd100 || d_v != 10'd1 || !d_hs || !d_vs || !d_de) hold_bad++;
    end
    chk("freeze_violations", hold_bad, 0);
    @(negedge clk) en = 1'b1;
    d_step(c);
    chk("resume_clks", c, 4);
    chk("resume_h", int'(d_h), 101);
    chk("resume_v", int'(d_v), 1);
    // reset mid-line with the divider mid-count
    d_goto(700);
    chk("pix_period_bad", per_bad, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    d_chk(rst_d, "midrst");
    chk("midrst_tick", int'(d_tick_o), 0);
    @(negedge clk) rst = 1'b0;
    d_step(c);
    chk("restart_clks", c, 4);
    d_chk(dv[0], "restart");
    // small build: HS_POL/VS_POL=1, CLK_DIV=1, H_TOTAL==2**CNT_W
    chk("s_rst_tick", int'(s_tick_o), 0);
    s_chk(rst_sm, "s_rst");
`ifdef VGA_PREFETCH_EN
    chk("s_rst_px", int'(s_px), 1);
    chk("s_rst_py", int'(s_py), 0);
    chk("s_rst_pd", int'(s_pd), 1);
`endif
    @(negedge clk) rst_s = 1'b0;
    @(posedge clk); #1;
    chk("s_first_tick", int'(s_tick_o), 1);
    for (int i = 0; i < 18; i++) begin
      s_goto(sv[i].h, sv[i].v);
      s_chk(sv[i], $sformatf("s%0d", i));
    end
    chk("s_frame_clks", s_clk, 160);
    chk("s_tick_gaps", s_tick_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
